call_request_latch: RTL and testbench
=====================================

// Module: call_request_latch
// PURPOSE
//  Front end for the Elevator core. Synchronises and debounces the 23 raw push-button inputs
//  (14 hall up/down calls, 7 car floor buttons, car door-open and door-close).
//  Floor calls are latched as pending requests and drive Elevator.floorButton / .internalButton.
//  A pending request is released when Elevator reports it served on nextFloorButton / nextInternalButton.
// PARAMETERS
//  DEBOUNCE_CLKS  4  consecutive synchronised samples a new level must hold before it is accepted (>=1)
// PORTS
//  clk                  input   1   system clock, rising edge
//  reset                input   1   asynchronous, active-high; clears all state
//  rawFloorButton       input   14  hall buttons; pair [2f-1:2f-2] = floor f, bit[2f-1]=UP, bit[2f-2]=DOWN
//  rawInternalButton    input   9   [9:1] car buttons; [7:1] floors 1-7, [8] door-open, [9] door-close
//  servedFloorButton    input   14  Elevator.nextFloorButton feedback
//  servedInternalButton input   9   [9:1] Elevator.nextInternalButton feedback
//  floorButton          output  14  latched hall requests -> Elevator.floorButton
//  internalButton       output  9   [9:1] [7:1] latched car requests, [9:8] debounced door levels
//  pendingCount         output  5   number of set bits in floorButton + internalButton[7:1] (0..19)
//  anyRequest           output  1   pendingCount != 0
// BEHAVIOUR
//  Reset: every sync flop, debounce counter, debounced level, edge register, pending bit and served_q
//   is cleared. floorButton=0, internalButton=0, pendingCount=0, anyRequest=0.
//  Sync: each of the 23 raw inputs passes through a 2-flop synchroniser (s1 -> s2).
//  Debounce (per input):
//   - Each input has its own deb level and counter. The counter is sized by $clog2(DEBOUNCE_CLKS+1).
//   - If s2==deb: cnt<=0.
//   - Else if cnt==DEBOUNCE_CLKS-1: deb<=s2 and cnt<=0.
//   - Else: cnt<=cnt+1.
//   - A glitch shorter than DEBOUNCE_CLKS samples never changes deb.
//  Press detect: press = deb & ~deb_q, where deb_q is deb delayed one clock. This gives a one-cycle pulse per accepted press.
//  Latch (floor bits and internal [7:1]):
//   - On press, the pending bit is set.
//   - On served fall (served_q==1 && served==0), the pending bit is cleared. served_q registers the served input every clock.
//   - If press and served fall occur on the same edge, press wins and the bit stays or becomes 1.
//   - Re-pressing an already pending button has no effect; there is no toggle-cancel.
//  Invalid calls: floorButton[0] (floor 1 DOWN) and floorButton[13] (floor 7 UP) are held at 0 always.
//   Their raw inputs are ignored.
//  Door bits internalButton[9:8] are the debounced levels, not latched. They are ignored by the served logic.
//  Latency, with DEBOUNCE_CLKS=D and raw asserted before edge 1:
//   - s1 at edge 1, s2 at edge 2, deb at edge 2+D, pending visible after edge 3+D (edge 7 for D=4).
//   - Door bits are visible after edge 2+D.
//  Release latency: a pending bit clears on the same edge that first samples served=0 after served=1.
//  pendingCount and anyRequest are combinational from the registered pending bits and track them with zero added delay.
//  Reset mid-debounce discards partial counts. A button held through reset is treated as a new press.
//   It latches D+3 edges after reset deasserts.
// TESTING
//  1. Reset -> all outputs 0. rawFloorButton=14'h3FFF held -> after edge 7, floorButton=14'h1FFE and pendingCount=12.
//  2. rawInternalButton[3] high for 3 clocks then low (D=4) -> internalButton[3] never sets, pendingCount stays 0.
//  3. rawInternalButton[5] held high for 10 clocks -> internalButton[5]=1 after edge 7, stays 1 after release, anyRequest=1.
//  4. Pending floorButton[4]=1; servedFloorButton[4] 1->0 -> floorButton[4]=0 on that edge, pendingCount decrements by 1.
//  5. Served fall on bit 4 on the same edge as an accepted press of bit 4 -> floorButton[4] stays 1.
//  6. Reset asserted on edge 4 of a D=4 debounce, then released with the button still held
//     -> outputs 0 during reset, bit latches 7 edges after release.
//  7. rawInternalButton[8] held 6 clocks -> internalButton[8] high from edge 6 and low D+2 edges after release.

Source files
------------

// File: rtl/call_request_latch.sv
// Button front end for the Elevator core: synchronises and debounces 23 push-buttons,
// latches floor/car calls until the core reports them served.
module call_request_latch #(
    parameter int unsigned DEBOUNCE_CLKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] rawFloorButton,
    input  logic [9:1]  rawInternalButton,
    input  logic [13:0] servedFloorButton,
    input  logic [9:1]  servedInternalButton,
    output logic [13:0] floorButton,
    output logic [9:1]  internalButton,
    output logic [4:0]  pendingCount,
    output logic        anyRequest
);

    localparam int unsigned NIN = 23;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CLKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLKS - 1);
    // Floor 1 DOWN and floor 7 UP do not exist; those pending bits never set.
    localparam logic [13:0] FLOOR_VALID = 14'h1FFE;

    // Bits [13:0] hall calls, [20:14] car floors 1-7, [22:21] door open/close.
    logic [NIN-1:0] raw;
    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic [NIN-1:0] deb;
    logic [NIN-1:0] debQ;
    logic [NIN-1:0] press;
    logic [CW-1:0]  cnt [NIN];

    logic [13:0] pendFloor;
    logic [7:1]  pendCar;
    logic [13:0] servedFloorQ;
    logic [7:1]  servedCarQ;
    logic [13:0] floorFall;
    logic [7:1]  carFall;

    // Door feedback has no pending bit to release.
    logic unusedServedDoor;
    assign unusedServedDoor = ^servedInternalButton[9:8];

    assign raw       = {rawInternalButton, rawFloorButton};
    assign press     = deb & ~debQ;
    assign floorFall = servedFloorQ & ~servedFloorButton;
    assign carFall   = servedCarQ & ~servedInternalButton[7:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            deb          <= '0;
            debQ         <= '0;
            for (int unsigned i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
            pendFloor    <= '0;
            pendCar      <= '0;
            servedFloorQ <= '0;
            servedCarQ   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            debQ  <= deb;
            for (int unsigned i = 0; i < NIN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            // OR-ing the press after the clear lets a coincident press win.
            pendFloor    <= ((pendFloor & ~floorFall) | press[13:0]) & FLOOR_VALID;
            pendCar      <= (pendCar & ~carFall) | press[20:14];
            servedFloorQ <= servedFloorButton;
            servedCarQ   <= servedInternalButton[7:1];
        end
    end

    assign floorButton    = pendFloor;
    assign internalButton = {deb[22:21], pendCar};

    always_comb begin
        pendingCount = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            pendingCount = pendingCount + 5'(pendFloor[i]);
        end
        for (int unsigned i = 1; i < 8; i++) begin
            pendingCount = pendingCount + 5'(pendCar[i]);
        end
    end

    assign anyRequest = (pendingCount != '0);

endmodule

// File: tb/tb_call_request_latch.sv
// Directed bench for call_request_latch with DEBOUNCE_CLKS=4: latency, glitch rejection,
// served release, press-vs-release priority, reset mid-debounce and door levels.
module tb_call_request_latch;

    logic        clk;
    logic        reset;
    logic [13:0] rawFloorButton;
    logic [9:1]  rawInternalButton;
    logic [13:0] servedFloorButton;
    logic [9:1]  servedInternalButton;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic [4:0]  pendingCount;
    logic        anyRequest;

    int tests = 0;
    int fails = 0;

    call_request_latch #(.DEBOUNCE_CLKS(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rawFloorButton      (rawFloorButton),
        .rawInternalButton   (rawInternalButton),
        .servedFloorButton   (servedFloorButton),
        .servedInternalButton(servedInternalButton),
        .floorButton         (floorButton),
        .internalButton      (internalButton),
        .pendingCount        (pendingCount),
        .anyRequest          (anyRequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [13:0] fb, input logic [8:0] ib,
                            input logic [4:0] pc, input logic ar);
        check({tag, ".floor"}, 32'(floorButton), 32'(fb));
        check({tag, ".internal"}, 32'(internalButton), 32'(ib));
        check({tag, ".count"}, 32'(pendingCount), 32'(pc));
        check({tag, ".any"}, 32'(anyRequest), 32'(ar));
    endtask

    initial begin
        reset                = 1'b1;
        rawFloorButton       = '0;
        rawInternalButton    = '0;
        servedFloorButton    = '0;
        servedInternalButton = '0;

        // 1: reset state, then all hall buttons held; invalid bits 0 and 13 stay clear
        tick(2);
        checkAll("reset", 14'h0000, 9'h000, 5'd0, 1'b0);
        reset          = 1'b0;
        rawFloorButton = 14'h3FFF;
        tick(6);
        checkAll("allHall.e6", 14'h0000, 9'h000, 5'd0, 1'b0);
        tick(1);
        checkAll("allHall.e7", 14'h1FFE, 9'h000, 5'd12, 1'b1);

        rawFloorButton = '0;
        reset          = 1'b1;
        tick(1);
        reset          = 1'b0;
        checkAll("reset2", 14'h0000, 9'h000, 5'd0, 1'b0);

        // 2: 3-clock glitch on car button 3 is rejected
        rawInternalButton = 9'h004;
        tick(3);
        rawInternalButton = '0;
        tick(10);
        checkAll("glitch", 14'h0000, 9'h000, 5'd0, 1'b0);

        // 3: car button 5 held 10 clocks latches at edge 7 and stays after release
        rawInternalButton = 9'h010;
        tick(6);
        check("car5.e6", 32'(internalButton), 32'h000);
        tick(1);
        checkAll("car5.e7", 14'h0000, 9'h010, 5'd1, 1'b1);
        tick(3);
        rawInternalButton = '0;
        tick(10);
        checkAll("car5.released", 14'h0000, 9'h010, 5'd1, 1'b1);

        // 4: hall bit 4 latched, then released by served falling edge
        rawFloorButton = 14'h0010;
        tick(7);
        check("fb4.set", 32'(floorButton), 32'h0010);
        check("fb4.count", 32'(pendingCount), 32'd2);
        rawFloorButton    = '0;
        servedFloorButton = 14'h0010;
        tick(1);
        check("fb4.servedHigh", 32'(floorButton), 32'h0010);
        servedFloorButton = '0;
        tick(1);
        checkAll("fb4.released", 14'h0000, 9'h010, 5'd1, 1'b1);

        // 5: re-press of bit 4 accepted on the same edge as a served fall -> press wins
        tick(10);
        rawFloorButton = 14'h0010;
        tick(5);
        servedFloorButton = 14'h0010;
        tick(1);
        check("collide.e6", 32'(floorButton), 32'h0000);
        servedFloorButton = '0;
        tick(1);
        checkAll("collide.e7", 14'h0010, 9'h010, 5'd2, 1'b1);
        tick(1);
        check("collide.e8", 32'(floorButton), 32'h0010);
        rawFloorButton = '0;

        // 6: reset asserted during edge 4 of a car-2 debounce, button held through it
        rawInternalButton = 9'h002;
        tick(3);
        reset = 1'b1;
        #1;
        checkAll("midReset.async", 14'h0000, 9'h000, 5'd0, 1'b0);
        tick(2);
        checkAll("midReset.held", 14'h0000, 9'h000, 5'd0, 1'b0);
        reset = 1'b0;
        tick(6);
        check("midReset.e6", 32'(internalButton), 32'h000);
        tick(1);
        checkAll("midReset.e7", 14'h0000, 9'h002, 5'd1, 1'b1);

        // 7: door-open held 6 clocks is a plain debounced level, not counted
        rawInternalButton = 9'h082;
        tick(5);
        check("door.e5", 32'(internalButton), 32'h002);
        tick(1);
        checkAll("door.e6", 14'h0000, 9'h082, 5'd1, 1'b1);
        rawInternalButton = 9'h002;
        tick(5);
        check("door.rel5", 32'(internalButton), 32'h082);
        tick(1);
        checkAll("door.rel6", 14'h0000, 9'h002, 5'd1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
